// File: rtl/mac_seq_pkg.sv
// Shared types and constants for the sequential multiply-accumulate controller.
// The overflow mode is chosen by MAC_SEQ_SAT_EN (see mac_seq_ctrl).
package mac_seq_pkg;

   localparam int OP_W  = 8;
   localparam int ACC_W = 16;

   localparam logic [ACC_W-1:0] SAT_VAL = 16'hFFFF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/mac_seq_dp.sv
// Combinational datapath: 8x8 unsigned multiply followed by a 16-bit add.
// The add's carry-out is reported so the controller can flag or saturate.
module mac_seq_dp
   import mac_seq_pkg::*;
(
   input  logic [OP_W-1:0]  a,
   input  logic [OP_W-1:0]  b,
   input  logic [ACC_W-1:0] acc,
   output logic [ACC_W-1:0] sum,
   output logic             carry
);

   logic [ACC_W-1:0] prod;

   always_comb begin
      prod         = ACC_W'(a) * ACC_W'(b);
      {carry, sum} = {1'b0, acc} + {1'b0, prod};
   end

endmodule

// File: rtl/mac_seq_ctrl.sv
// Job controller: accepts len operand pairs, accumulates a*b, presents the sum.
// Define MAC_SEQ_SAT_EN to saturate the accumulator instead of wrapping.
module mac_seq_ctrl
   import mac_seq_pkg::*;
#(
   parameter int LEN_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       a,
   input  logic [7:0]       b,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [15:0]      res,
   output logic             ovf,
   output logic             busy
);

   state_e           state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;

   logic [ACC_W-1:0] dp_sum;
   logic             dp_carry;

   mac_seq_dp u_dp (
      .a     (a),
      .b     (b),
      .acc   (acc_q),
      .sum   (dp_sum),
      .carry (dp_carry)
   );

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               acc_d = '0;
               ovf_d = 1'b0;
               if (len == '0) begin
                  state_d = DONE;
               end else begin
                  cnt_d   = len;
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            if (in_valid) begin
`ifdef MAC_SEQ_SAT_EN
               // Once pinned at the ceiling every later add carries again, so it stays there.
               acc_d = dp_carry ? SAT_VAL : dp_sum;
`else
               acc_d = dp_sum;
`endif
               ovf_d = ovf_q | dp_carry;
               cnt_d = cnt_q - LEN_W'(1);
               if (cnt_q == LEN_W'(1)) state_d = DONE;
            end
         end
         DONE: begin
            if (res_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
      end
   end

   // All outputs decode straight from registers, so reset clears them without waiting for clk.
   assign in_ready  = (state_q == RUN);
   assign res_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign res       = acc_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl with hand-computed expectations.
module tb_mac_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [3:0]  len;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  a, b;
   logic        res_valid;
   logic        res_ready;
   logic [15:0] res;
   logic        ovf;
   logic        busy;

   int n_chk  = 0;
   int n_pass = 0;

   mac_seq_ctrl #(.LEN_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .len       (len),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res       (res),
      .ovf       (ovf),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] x, input logic [7:0] y);
      in_valid = 1'b1; a = x; b = y;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic begin_job(input logic [3:0] n);
      start = 1'b1; len = n;
      tick();
      start = 1'b0;
   endtask

   task automatic finish_job();
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0;
      a = '0; b = '0; res_ready = 1'b0;
      #3;
      check("rst_busy", busy, 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_res", res, 0);
      check("rst_ovf", ovf, 0);
      tick();
      rst = 1'b0;
      tick();
      check("idle_in_ready", in_ready, 0);

      // Basic job: 6 + 20 + 100 = 126
      begin_job(4'd3);
      check("basic_in_ready", in_ready, 1);
      check("basic_busy", busy, 1);
      send(8'd2, 8'd3);
      in_valid = 1'b1; a = 8'd4; b = 8'd5;
      tick();
      check("basic_not_done", res_valid, 0);
      a = 8'd10; b = 8'd10;
      tick();
      in_valid = 1'b0;
      check("basic_res_valid", res_valid, 1);
      check("basic_in_ready_drop", in_ready, 0);
      check("basic_res", res, 126);
      check("basic_ovf", ovf, 0);
      finish_job();
      check("basic_busy_drop", busy, 0);

      // Overflow job: 0xFE01 + 0xFE01 carries out of bit 15
      begin_job(4'd2);
      send(8'd255, 8'd255);
      check("ovf_first_no_flag", ovf, 0);
      send(8'd255, 8'd255);
      check("ovf_res_valid", res_valid, 1);
`ifdef MAC_SEQ_SAT_EN
      check("ovf_res", res, 16'hFFFF);
`else
      check("ovf_res", res, 16'hFC02);
`endif
      check("ovf_flag", ovf, 1);
      finish_job();

      // Backpressure: 12 + 30 = 42, gaps on both sides
      begin_job(4'd2);
      check("bp_ovf_cleared", ovf, 0);
      send(8'd3, 8'd4);
      for (int i = 0; i < 4; i++) begin
         check("bp_gap_in_ready", in_ready, 1);
         check("bp_gap_res_valid", res_valid, 0);
         check("bp_gap_res", res, 12);
         tick();
      end
      send(8'd5, 8'd6);
      for (int i = 0; i < 5; i++) begin
         check("bp_hold_valid", res_valid, 1);
         check("bp_hold_res", res, 42);
         start = (i % 2 == 0); len = 4'd1;
         tick();
         start = 1'b0;
      end
      check("bp_start_ignored", res_valid, 1);
      check("bp_res_after_start", res, 42);
      start = 1'b1; len = 4'd1; res_ready = 1'b1;
      tick();
      start = 1'b0; res_ready = 1'b0;
      check("bp_busy_drop", busy, 0);
      check("bp_res_valid_drop", res_valid, 0);
      tick();
      check("bp_no_queued_job", busy, 0);

      // Zero-length job
      begin_job(4'd0);
      check("zero_res_valid", res_valid, 1);
      check("zero_res", res, 0);
      check("zero_in_ready", in_ready, 0);
      check("zero_ovf", ovf, 0);
      finish_job();
      check("zero_in_ready_after", in_ready, 0);
      check("zero_busy", busy, 0);

      // Mid-job reset after 2 of 4 transfers
      begin_job(4'd4);
      send(8'd1, 8'd1);
      send(8'd2, 8'd2);
      check("mid_partial", res, 5);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_in_ready", in_ready, 0);
      check("mid_rst_res_valid", res_valid, 0);
      check("mid_rst_res", res, 0);
      check("mid_rst_ovf", ovf, 0);
      tick();
      rst = 1'b0;
      tick();
      check("mid_idle_after", busy, 0);
      begin_job(4'd1);
      send(8'd7, 8'd6);
      check("after_rst_valid", res_valid, 1);
      check("after_rst_res", res, 42);
      finish_job();
      check("after_rst_busy", busy, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/mac_seq_ctrl.md
MAC_SEQ_CTRL -- requirements
Module: mac_seq_ctrl

Interface
REQ-001 Parameter: LEN_W, default 4, width of the job-length field (max job = 2^LEN_W - 1 operand pairs).
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1: single clock, rising edge.
- rst, in, 1: asynchronous, active-high reset.
- start, in, 1: job request, sampled only in IDLE.
- len, in, LEN_W: number of operand pairs in the job, captured with start.
- in_valid, in, 1: operand pair valid.
- in_ready, out, 1: controller accepts the operand pair.
- a, in, 8: unsigned multiplicand.
- b, in, 8: unsigned multiplier.
- res_valid, out, 1: result available.
- res_ready, in, 1: consumer accepts the result.
- res, out, 16: accumulated sum of products.
- ovf, out, 1: sticky flag, set if any accumulation carried out of bit 15 during the job.
- busy, out, 1: high in any state other than IDLE.

Function
REQ-003 FSM has three states: IDLE, RUN, DONE.
REQ-004 IDLE: in_ready=0, res_valid=0; start=1 with len!=0 clears the accumulator and ovf, loads a down-counter with len, and moves to RUN.
REQ-005 IDLE: start=1 with len=0 clears the accumulator and ovf and moves directly to DONE, so res=0 is valid on the next cycle.
REQ-006 RUN: in_ready=1; a transfer occurs on in_valid&&in_ready, which adds a*b (16-bit product) to the 16-bit accumulator and decrements the counter.
REQ-007 RUN: cycles with in_valid=0 hold the accumulator and counter unchanged; gaps of any length are legal.
REQ-008 The transfer that brings the counter to 0 moves the FSM to DONE on the same edge; in_ready is 0 from the next cycle.
REQ-009 Latency: res_valid rises on the cycle after the last accepted pair; the accumulator is registered and there is no further pipeline.
REQ-010 DONE: res_valid=1; res and ovf stay stable until res_valid&&res_ready, which returns the FSM to IDLE.
REQ-011 Overflow: the default arithmetic is modulo 2^16 wrap; ovf is set on any carry out of bit 15 and stays set until the next job start.
REQ-012 start is ignored in RUN and DONE; no job is queued.
REQ-013 in_valid is ignored outside RUN.
REQ-014 A result handshake and a start in the same cycle: the handshake completes, and start is ignored because it was not sampled in IDLE.

Reset
REQ-015 rst=1 forces state IDLE, accumulator 0, counter 0, ovf 0, res 0, res_valid 0, in_ready 0, busy 0, immediately and regardless of clk.
REQ-016 Reset asserted mid-job aborts the job; no partial result is ever presented.

Configuration
REQ-017 The macro MAC_SEQ_SAT_EN selects the overflow behaviour.
- Defined: the accumulator saturates at 16'hFFFF and stays there for the rest of the job; ovf behaves as in REQ-011.
- Undefined: the accumulator wraps as in REQ-011.

Structure
REQ-018 Package mac_seq_pkg holds:
- the state enum (IDLE, RUN, DONE);
- the constants OP_W=8 and ACC_W=16;
- the saturation value 16'hFFFF.
REQ-019 One sub-module, mac_seq_dp: a combinational 8x8 multiply plus 16-bit add with carry-out. The controller owns all registers.

Verification
REQ-020 Basic job: len=3, pairs (2,3),(4,5),(10,10) sent back-to-back -> res=126, ovf=0, res_valid exactly 1 cycle after the 3rd transfer.
REQ-021 Overflow job: len=2, pairs (255,255),(255,255) -> res=16'hFC02 and ovf=1 without the macro; res=16'hFFFF and ovf=1 with MAC_SEQ_SAT_EN.
REQ-022 Backpressure: len=2, in_valid low for 4 cycles between the two pairs, res_ready low for 5 cycles after res_valid rises.
- Required: res stays constant throughout.
- Required: start pulses issued during DONE are ignored.
- Required: busy drops the cycle after the result handshake.
REQ-023 Zero-length job: len=0 with start -> res_valid=1 and res=0 on the next cycle, with no in_ready pulse.
REQ-024 Mid-job reset: len=4, rst asserted after 2 transfers -> all outputs are 0 immediately. A following job with len=1 and pair (7,6) gives res=42.
